// File: rtl/nn_ctrl_pkg.sv
// Shared types and default sizing for the neural-network control blocks.
package nn_ctrl_pkg;

  // Default layer geometry and the index widths that cover it.
  localparam int DEF_NUM_ROWS = 3;
  localparam int DEF_NUM_COLS = 3;
  localparam int DEF_ROW_W    = 2;
  localparam int DEF_COL_W    = 2;

  // Layer-pass sequencer states. ACTIVATE is only reachable when the
  // activation stage is built in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    ACTIVATE = 3'd2,
    WRITE    = 3'd3,
    FINISH   = 3'd4
  } layer_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Generic modulo-N counter: synchronous clear, increment, last_value flag.
module wrap_counter #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         last_value
);

  assign last_value = (value == W'(N - 1));

  // Count 0..N-1 and wrap; clear has priority over increment.
  always_ff @(posedge clock) begin
    if (clear)
      value <= '0;
    else if (inc)
      value <= last_value ? '0 : value + W'(1);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Fully-connected layer pass sequencer: walks rows x cols, drives MAC,
// accumulator load, optional activation and result write strobes.
// Optional feature macro: LAYER_SEQ_ACT_STAGE_EN adds an ACTIVATE state
// between the last ACCUM beat of each row and its WRITE.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int COL_W    = DEF_COL_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             operand_valid,
  output logic             mac_enable,
  output logic             acc_load,
  output logic [ROW_W-1:0] row_index,
  output logic [COL_W-1:0] col_index,
  output logic             write_enable,
  output logic             act_enable,
  output logic             busy,
  output logic             done
);

  layer_state_t state;
  logic row_last, col_last;
  logic row_inc, col_inc;
  logic cnt_clear;

  // Counters restart on reset and whenever the sequencer sits in IDLE, so
  // every accepted pass begins at row 0, col 0.
  assign cnt_clear = clear | (state == IDLE);
  assign col_inc   = (state == ACCUM) & operand_valid;
  assign row_inc   = (state == WRITE);

  wrap_counter #(.N(NUM_COLS), .W(COL_W)) u_col_cnt (
    .clock      (clock),
    .clear      (cnt_clear),
    .inc        (col_inc),
    .value      (col_index),
    .last_value (col_last)
  );

  wrap_counter #(.N(NUM_ROWS), .W(ROW_W)) u_row_cnt (
    .clock      (clock),
    .clear      (cnt_clear),
    .inc        (row_inc),
    .value      (row_index),
    .last_value (row_last)
  );

  // Pass control FSM; clear overrides every other input.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   if (start) state <= ACCUM;
        ACCUM:
          if (operand_valid && col_last) begin
`ifdef LAYER_SEQ_ACT_STAGE_EN
            state <= ACTIVATE;
`else
            state <= WRITE;
`endif
          end
`ifdef LAYER_SEQ_ACT_STAGE_EN
        ACTIVATE: state <= WRITE;
`endif
        WRITE:  state <= row_last ? FINISH : ACCUM;
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the registered state and counters; the MAC
  // additionally waits on operand_valid so stalls cost no spurious beats.
  assign mac_enable   = (state == ACCUM) & operand_valid;
  assign acc_load     = mac_enable & (col_index == '0);
  assign write_enable = (state == WRITE);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

`ifdef LAYER_SEQ_ACT_STAGE_EN
  assign act_enable = (state == ACTIVATE);
`else
  assign act_enable = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes the expected output
// vector for each driven cycle, a negedge monitor pops and compares.
module tb_layer_sequencer;
  import nn_ctrl_pkg::*;

  localparam int NR = DEF_NUM_ROWS;
  localparam int NC = DEF_NUM_COLS;
`ifdef LAYER_SEQ_ACT_STAGE_EN
  localparam bit ACT = 1'b1;
`else
  localparam bit ACT = 1'b0;
`endif
  localparam int L   = NC + 1 + (ACT ? 1 : 0); // cycles per row
  localparam int FIN = NR * L + 1;              // FINISH cycle

  typedef struct packed {
    logic mac, acc, wr, act, busy, done;
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W-1:0] col;
  } obs_t;

  logic clock = 1'b0;
  logic clear = 1'b1, start = 1'b0, operand_valid = 1'b0;
  logic mac_enable, acc_load, write_enable, act_enable, busy, done;
  logic [DEF_ROW_W-1:0] row_index;
  logic [DEF_COL_W-1:0] col_index;

  layer_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .operand_valid(operand_valid),
    .mac_enable(mac_enable), .acc_load(acc_load), .row_index(row_index),
    .col_index(col_index), .write_enable(write_enable), .act_enable(act_enable),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  obs_t  sb_q[$];
  string nm_q[$];
  int    cy_q[$];
  int    checks = 0, failures = 0;

  // Monitor: compare the DUT's outputs against the expected vector for the cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      obs_t e, a;
      string n;
      int c;
      e = sb_q.pop_front(); n = nm_q.pop_front(); c = cy_q.pop_front();
      a = '{mac_enable, acc_load, write_enable, act_enable, busy, done,
            row_index, col_index};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s cyc=%0d got mac/acc/wr/act/busy/done=%b%b%b%b%b%b row=%0d col=%0d want %b%b%b%b%b%b row=%0d col=%0d",
                 n, c, a.mac, a.acc, a.wr, a.act, a.busy, a.done, a.row, a.col,
                 e.mac, e.acc, e.wr, e.act, e.busy, e.done, e.row, e.col);
      end
    end
  end

  // Expected outputs for cycle c of an unstalled pass (start sampled at edge 0).
  function automatic obs_t pass_exp(int c);
    obs_t e;
    int r, k;
    e = '0;
    if (c < 1 || c > FIN) return e;
    e.busy = 1'b1;
    if (c == FIN) begin e.done = 1'b1; return e; end
    r = (c - 1) / L;
    k = (c - 1) % L;
    e.row = DEF_ROW_W'(r);
    if (k < NC) begin
      e.mac = 1'b1; e.acc = (k == 0); e.col = DEF_COL_W'(k);
    end else if (ACT && k == NC) begin
      e.act = 1'b1;
    end else begin
      e.wr = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle's inputs, optionally queue its expected outputs.
  task automatic step(input bit st, input bit ov, input bit clr, input bit chk,
                      input obs_t e, input string nm, input int cyc);
    start = st; operand_valid = ov; clear = clr;
    if (chk) begin sb_q.push_back(e); nm_q.push_back(nm); cy_q.push_back(cyc); end
    @(posedge clock); #1;
  endtask

  task automatic run_pass(input string nm, input bit busy_starts);
    for (int c = 0; c <= FIN + 1; c++)
      step((c == 0) || (busy_starts && (c == 6 || c == FIN)), 1'b1, 1'b0,
           1'b1, pass_exp(c), nm, c);
  endtask

  localparam int S = 3; // stall length
  obs_t stall_e;

  initial begin
    @(posedge clock); #1;
    // Reset, then idle checks.
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, "reset", 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "reset_idle", 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "reset_idle", 1);

    // Basic pass with operand_valid held high.
    run_pass("pass", 1'b0);

    // Stall in row 0: operand_valid low at cycles 2..4, col held at 1.
    stall_e = '0; stall_e.busy = 1'b1; stall_e.col = DEF_COL_W'(1);
    for (int c = 0; c <= FIN + S + 1; c++) begin
      if (c < 2)          step(c == 0, 1'b1, 1'b0, 1'b1, pass_exp(c), "stall", c);
      else if (c < 2 + S) step(1'b0, 1'b0, 1'b0, 1'b1, stall_e, "stall", c);
      else                step(1'b0, 1'b1, 1'b0, 1'b1, pass_exp(c - S), "stall", c);
    end

    // Start while busy and during FINISH is ignored; one done, then IDLE.
    run_pass("busy_start", 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "busy_start_idle", FIN + 2);

    // Clear mid-pass at cycle 6 (row 1, col 1), then a clean full pass.
    for (int c = 0; c <= 6; c++)
      step(c == 0, 1'b1, c == 6, 1'b1, pass_exp(c), "mid_clear", c);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "mid_clear_idle", 7);
    run_pass("after_clear", 1'b0);

    // Clear and start together in IDLE: clear wins.
    step(1'b1, 1'b1, 1'b1, 1'b1, '0, "clr_start", 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "clr_start", 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, "clr_start", 2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clock);
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences one fully-connected layer pass: walks row_index over NUM_ROWS output neurons and col_index over NUM_COLS inputs per row.
- Drives MAC enable, accumulator load, and result write strobes to the neuron datapath.
- Sits between the top-level network controller (start/done handshake) and the weight-memory/MAC datapath.
- Stalls on an operand-valid input.

Parameters:
- NUM_ROWS, 3, output neurons per layer (row_index wraps at NUM_ROWS-1).
- NUM_COLS, 3, inputs per neuron (col_index wraps at NUM_COLS-1).
- ROW_W, 2, width of row_index; must satisfy 2^ROW_W >= NUM_ROWS.
- COL_W, 2, width of col_index; must satisfy 2^COL_W >= NUM_COLS.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- clear  input  1  synchronous, active-high reset; sampled on posedge clock.
- start  input  1  request a layer pass; accepted only in IDLE.
- operand_valid  input  1  weight and input operands present this cycle.
- mac_enable  output  1  datapath performs a MAC this cycle.
- acc_load  output  1  qualifies mac_enable; the accumulator takes the product instead of adding it.
- row_index  output  ROW_W  current neuron row.
- col_index  output  COL_W  current input column.
- write_enable  output  1  store the accumulator to result[row_index].
- act_enable  output  1  activation stage strobe; constant 0 unless the macro is defined.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- States: IDLE, ACCUM, WRITE, FINISH (plus ACTIVATE with the macro).
- State and both counters are registered. Outputs are decoded from state and counters; mac_enable additionally ANDs in operand_valid.
- Reset: clear=1 at a posedge forces state=IDLE, row_index=0, col_index=0 from any state, including mid-pass. The next cycle all strobes, busy and done are 0. clear wins over start and operand_valid in the same cycle.
- IDLE: all strobes 0.
  - start=1 -> ACCUM with row=0, col=0.
  - start while busy is ignored; it is not queued.
- ACCUM:
  - mac_enable = operand_valid.
  - acc_load = (col_index==0) & operand_valid.
  - operand_valid=0: hold state and counters (stall of any length).
  - operand_valid=1 and col<NUM_COLS-1: col++.
  - operand_valid=1 and col==NUM_COLS-1: col wraps to 0, go to WRITE (ACTIVATE with macro).
- WRITE: write_enable=1 for exactly one cycle with the current row_index.
  - row<NUM_ROWS-1: row++ and return to ACCUM.
  - row==NUM_ROWS-1: row wraps to 0, go to FINISH.
- FINISH: done=1, busy=1 for one cycle, then IDLE. A start asserted during FINISH is ignored.
- Latency with operand_valid held at 1 and start accepted at edge 0:
  - ACCUM occupies cycles 1..NUM_COLS; WRITE follows; FINISH at cycle NUM_ROWS*(NUM_COLS+1)+1.
  - Defaults: WRITE at cycles 4, 8, 12; done at cycle 13.
- Counters never exceed NUM_ROWS-1 / NUM_COLS-1. Out-of-range values cannot be reached.
- mac_enable and write_enable are never high in the same cycle.

Optional Feature:
- LAYER_SEQ_ACT_STAGE_EN defined: an ACTIVATE state sits between the last ACCUM beat and WRITE.
  - ACTIVATE drives act_enable=1 for one cycle, with row_index unchanged.
  - Each row costs NUM_COLS+2 cycles; defaults give done at cycle 16.
- Undefined: ACTIVATE state absent, act_enable tied 0, timing as above.

Decomposition:
- Package nn_ctrl_pkg holds:
  - the layer_state_t enum (IDLE, ACCUM, ACTIVATE, WRITE, FINISH);
  - default NUM_ROWS/NUM_COLS localparams;
  - the index width constants.
- Natural sub-module: wrap_counter, a generic modulo-N counter with clear, increment and last_value.
  - Instantiated twice, once for the row counter and once for the column counter.
  - The FSM only issues increment/clear and reads last_value.

Test Plan:
- Defaults, operand_valid=1, start at cycle 0:
  - write_enable at cycles 4, 8, 12 with row_index 0, 1, 2;
  - acc_load at cycles 1, 5, 9;
  - done only at cycle 13; busy high cycles 1..13.
- Stall: operand_valid=0 at cycles 2-4 in row 0 -> col_index holds at 1, mac_enable=0; first write_enable moves to cycle 7 and done to cycle 16.
- Start while busy (cycle 6) and during FINISH -> ignored; exactly one done; IDLE at cycle 14.
- clear at cycle 6 (row 1, col 1) -> cycle 7: IDLE, row=0, col=0, all outputs 0; a new start produces a full, correct pass.
- clear and start together in IDLE -> stays IDLE, busy=0.
- With LAYER_SEQ_ACT_STAGE_EN, defaults:
  - act_enable at cycles 4, 9, 14;
  - write_enable at cycles 5, 10, 15;
  - done at cycle 16.
